// File: rtl/text_render_if.sv
// Character load stream into text_render.
// master drives char_valid/char_data/char_last; slave returns char_ready.
interface text_render_if;
  logic       char_valid;
  logic [4:0] char_data;
  logic       char_last;
  logic       char_ready;

  modport master (
    output char_valid,
    output char_data,
    output char_last,
    input  char_ready
  );

  modport slave (
    input  char_valid,
    input  char_data,
    input  char_last,
    output char_ready
  );
endinterface

// File: rtl/text_render.sv
// One-line text overlay: 16-slot message buffer, 2-stage pixel pipeline.
// Ports: sys_clk, sys_rst_n (sync, active-low), pix_x/pix_y/pix_valid
// scan position, load_start, chr (text_render_if.slave char stream),
// letter_i/x/y glyph lookup out, letter_o glyph bit in, text_pix,
// text_valid. Optional blink: define TEXT_BLINK_EN.
module text_render #(
  parameter logic [9:0] ORIGIN_X     = 10'd256,
  parameter logic [9:0] ORIGIN_Y     = 10'd232,
  parameter logic [5:0] BLINK_FRAMES = 6'd30
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       pix_valid,
  input  logic       load_start,
  text_render_if.slave chr,
  output logic [4:0] letter_i,
  output logic [3:0] letter_x,
  output logic [3:0] letter_y,
  input  logic       letter_o,
  output logic       text_pix,
  output logic       text_valid
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHOW
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] ptr;
  logic [3:0] ptr_nxt;
  logic [4:0] len;
  logic [4:0] len_nxt;
  logic       wr_en;
  logic       accept;
  logic [4:0] msg [16];

  logic       visible;

  assign chr.char_ready = (state == LOAD);
  assign accept = chr.char_valid && (state == LOAD);

  // A load_start always wins over a same-cycle character.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    len_nxt   = len;
    wr_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start) begin
          state_nxt = LOAD;
          ptr_nxt   = 4'd0;
          len_nxt   = 5'd0;
        end
      end
      LOAD: begin
        if (load_start) begin
          ptr_nxt = 4'd0;
          len_nxt = 5'd0;
        end else if (accept) begin
          wr_en   = 1'b1;
          ptr_nxt = ptr + 4'd1;
          if (chr.char_last || ptr == 4'd15) begin
            state_nxt = SHOW;
            len_nxt   = {1'b0, ptr} + 5'd1;
          end
        end
      end
      SHOW: begin
        if (load_start) begin
          state_nxt = LOAD;
          ptr_nxt   = 4'd0;
          len_nxt   = 5'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      ptr   <= 4'd0;
      len   <= 5'd0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      len   <= len_nxt;
    end
  end

  // Buffer contents are left alone by reset; len alone gates them.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_n && wr_en) begin
      msg[ptr] <= chr.char_data;
    end
  end

  // Stage 1: box test and glyph addressing.
  logic [9:0] dx;
  logic [9:0] dy;
  logic [9:0] span;
  logic       in_box;
  logic       in_box_d;
  logic       valid_d1;

  assign dx   = pix_x - ORIGIN_X;
  assign dy   = pix_y - ORIGIN_Y;
  assign span = {1'b0, len, 4'b0000};

  // dx < span <= 256 keeps dx[7:4] a valid slot index.
  assign in_box = pix_valid
               && (pix_x >= ORIGIN_X)
               && (dx < span)
               && (pix_y >= ORIGIN_Y)
               && (dy < 10'd16);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      letter_i <= 5'd0;
      letter_x <= 4'd0;
      letter_y <= 4'd0;
      in_box_d <= 1'b0;
      valid_d1 <= 1'b0;
    end else begin
      in_box_d <= in_box;
      valid_d1 <= pix_valid;
      if (in_box) begin
        letter_i <= msg[dx[7:4]];
        letter_x <= dx[3:0];
        letter_y <= dy[3:0];
      end
    end
  end

  // Stage 2: codes 26-31 render as blank.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      text_pix   <= 1'b0;
      text_valid <= 1'b0;
    end else begin
      text_pix   <= letter_o
                 && in_box_d
                 && (state == SHOW)
                 && (letter_i < 5'd26)
                 && visible;
      text_valid <= valid_d1;
    end
  end

`ifdef TEXT_BLINK_EN
  logic [5:0] frame_cnt;
  logic       frame_start;

  assign frame_start = pix_valid
                    && (pix_x == 10'd0)
                    && (pix_y == 10'd0);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      frame_cnt <= 6'd0;
      visible   <= 1'b1;
    end else if (frame_start) begin
      if (frame_cnt == BLINK_FRAMES - 6'd1) begin
        frame_cnt <= 6'd0;
        visible   <= ~visible;
      end else begin
        frame_cnt <= frame_cnt + 6'd1;
      end
    end
  end
`else
  logic unused_blink;

  assign visible      = 1'b1;
  assign unused_blink = ^BLINK_FRAMES;
`endif

endmodule

// File: doc/text_render.md
TEXT_RENDER -- requirements
Module: text_render

Interface
REQ-001 Parameter ORIGIN_X, default 10'd256: pixel column of the left edge of character slot 0.
REQ-002 Parameter ORIGIN_Y, default 10'd232: pixel row of the top edge of the text line.
REQ-003 Parameter BLINK_FRAMES, default 6'd30: frames per blink half-period; used only with TEXT_BLINK_EN.
REQ-004 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-005 sys_rst_n  in  1  reset, synchronous, active-low.
REQ-006 pix_x  in  10  current scan column.
REQ-007 pix_y  in  10  current scan row.
REQ-008 pix_valid  in  1  pix_x/pix_y are a visible pixel this cycle.
REQ-009 load_start  in  1  one-cycle pulse; begins a new message load.
REQ-010 char_valid  in  1  char_data is offered.
REQ-011 char_data  in  5  glyph code: 0-25 = A-Z; 31 = blank; 26-30 = reserved, rendered as blank.
REQ-012 char_last  in  1  qualifies char_valid; marks the final character.
REQ-013 char_ready  out  1  block accepts char_data this cycle.
REQ-014 letter_i  out  5  glyph code to the glyph lookup.
REQ-015 letter_x  out  4  column within the 16x16 glyph.
REQ-016 letter_y  out  4  row within the 16x16 glyph.
REQ-017 letter_o  in  1  glyph pixel returned combinationally for the current letter_i/x/y.
REQ-018 text_pix  out  1  text foreground pixel.
REQ-019 text_valid  out  1  text_pix corresponds to a pix_valid pixel from 2 cycles earlier.

Function
REQ-020 The message buffer SHALL hold 16 entries of 5 bits, plus a 5-bit length len (0-16).
REQ-021 The FSM SHALL have states IDLE, LOAD and SHOW.
- IDLE->LOAD on load_start.
- LOAD->SHOW on an accepted char_last, or on acceptance of the 16th character.
- SHOW->LOAD on load_start.
REQ-022 On entry to LOAD, the write pointer and len SHALL clear to 0.
REQ-023 load_start while in LOAD SHALL restart the load; the pointer clears again.
REQ-024 char_ready SHALL be 1 only in LOAD.
- An accept is char_valid&&char_ready: it writes buf[ptr], then ptr+1.
- On the final accept, len = ptr+1.
- char_valid outside LOAD SHALL be ignored.
REQ-025 If load_start and char_valid occur in the same cycle in LOAD, the restart SHALL win and the character SHALL be dropped.
REQ-026 Stage 1 SHALL register the following from the pix_* inputs:
- dx = pix_x-ORIGIN_X and dy = pix_y-ORIGIN_Y, both 10-bit unsigned.
- in_box = pix_valid && pix_x>=ORIGIN_X && dx<len*16 && pix_y>=ORIGIN_Y && dy<16.
- letter_i = buf[dx[7:4]], letter_x = dx[3:0], letter_y = dy[3:0].
REQ-027 Stage 2 SHALL register text_pix = letter_o && in_box_d && (state==SHOW) && letter_i<26 && visible.
REQ-028 Stage 2 SHALL register text_valid = pix_valid delayed 2 cycles; latency is exactly 2 cycles.
REQ-029 letter_i/x/y SHALL hold their last values while in_box is 0.
REQ-030 len=0 SHALL produce no foreground pixels.
REQ-031 Ranges beyond 16 slots SHALL never index the buffer out of range.
REQ-032 The buffer SHALL NOT be reset; only len SHALL be reset.
REQ-033 A frame start SHALL be pix_valid && pix_x==0 && pix_y==0.

Reset
REQ-034 When sys_rst_n=0 at a clock edge, the following SHALL apply on the next cycle:
- state = IDLE, ptr = 0, len = 0.
- char_ready = 0.
- letter_i/x/y = 0.
- text_pix = 0, text_valid = 0, pipeline valids = 0.
- blink counter = 0, visible = 1.
REQ-035 A reset asserted during LOAD SHALL abandon the load; a new load_start is required afterwards.

Configuration
REQ-036 With TEXT_BLINK_EN defined:
- A 6-bit frame counter SHALL increment on each frame start.
- On reaching BLINK_FRAMES-1, the counter SHALL wrap to 0 and toggle visible.
REQ-037 Without TEXT_BLINK_EN, visible SHALL be constant 1 and the counter SHALL not exist.

Verification
REQ-038 Reset, then load "HI" (codes 7, 8, char_last on 8), then pixel (256,232) valid with the ROM stub returning 1 -> text_pix=1, text_valid=1 exactly 2 cycles later; char_ready=0 after the accept of char 8.
REQ-039 Same message, pixel (288,232) (slot 2, beyond len=2) -> text_pix=0; pixel (255,232) -> 0; pixel (256,248) -> 0.
REQ-040 Load 17 characters back-to-back -> state SHOW after the 16th accept, len=16, char_ready=0 on the 17th cycle, buf[0] unchanged.
REQ-041 Load of codes 0, 31, 27 (last) with the ROM stub at 1 -> slot 0 lit, slots 1 and 2 dark.
REQ-042 In LOAD, after 3 accepts, pulse load_start together with char_valid -> ptr=0, character dropped, text_pix=0 until SHOW.
REQ-043 With TEXT_BLINK_EN and BLINK_FRAMES=2 -> text_pix lit in frames 0-1, dark in frames 2-3, lit in frame 4; without the macro -> lit in all frames.
